// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer drives operands; the block returns one result per operation.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB-first, one bit per clock,
// through a single full-subtract cell and a borrow register.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_next = {d, res[WIDTH-1:1]};
    end

    // Results are published only on the final bit edge, so diff never shows partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            res         <= '0;
            cnt         <= '0;
            br          <= 1'b0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        br         <= bus.borrow_in;
                        a_msb      <= bus.a[WIDTH-1];
                        b_msb      <= bus.b[WIDTH-1];
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res  <= res_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff_q      <= res_next;
                        borrow_q    <= br_next;
                        ovf_q       <= (a_msb != b_msb) & (d != a_msb);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: expected results are queued from an arithmetic
// model when operands are accepted and compared when out_valid appears.
module tb_serial_sub;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cyc;
    int   accept_cyc;
    exp_t sb[$];

    serial_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic bin);
        exp_t         r;
        logic [WIDTH:0] full;
        int           sr;
        full     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        sr       = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.diff   = full[WIDTH-1:0];
        r.borrow = full[WIDTH];
        r.ovf    = (sr > 127) || (sr < -128);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bin;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        accept_cyc    = cyc;
        sb.push_back(model(a, b, bin));
    endtask

    // Waits for the result, holds off the consumer for 'hold' cycles while checking
    // that the result stays frozen, then completes the handshake.
    task automatic checkOutput(input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_wait", 32'(bus.out_valid), 32'd1);
        check("latency", 32'(cyc - accept_cyc), 32'(WIDTH));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i <= hold; i++) begin
                check("out_valid_hold", 32'(bus.out_valid), 32'd1);
                check("in_ready_done", 32'(bus.in_ready), 32'd0);
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("borrow_out", 32'(bus.borrow_out), 32'(e.borrow));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
                if (i < hold) begin
                    @(posedge clk); #1;
                end
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
            check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
            check("diff_retained", 32'(bus.diff), 32'(e.diff));
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        accept_cyc    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow", 32'(bus.borrow_out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);

        $display("[TB] basic and borrow/overflow vectors");
        applyStimulus(8'h05, 8'h03, 1'b0); checkOutput(0);
        applyStimulus(8'h03, 8'h05, 1'b0); checkOutput(0);
        applyStimulus(8'h00, 8'h00, 1'b1); checkOutput(0);
        applyStimulus(8'h80, 8'h01, 1'b0); checkOutput(0);
        applyStimulus(8'h7F, 8'hFF, 1'b0); checkOutput(0);
        applyStimulus(8'h80, 8'h00, 1'b1); checkOutput(0);

        $display("[TB] backpressure");
        applyStimulus(8'h5A, 8'h33, 1'b1); checkOutput(5);

        $display("[TB] in_valid during RUN is ignored");
        applyStimulus(8'h05, 8'h03, 1'b0);
        @(posedge clk); #1;
        bus.a        = 8'hAA;
        bus.b        = 8'h11;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput(0);
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("no_queued_op_valid", 32'(bus.out_valid), 32'd0);
        check("no_queued_op_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] reset mid-run");
        applyStimulus(8'h33, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("midrst_no_output", 32'(bus.out_valid), 32'd0);
        applyStimulus(8'h10, 8'h01, 1'b0); checkOutput(0);

        $display("[TB] random vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
            checkOutput(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor: accepts two operands plus borrow-in over a valid/ready handshake, computes a - b - borrow_in LSB-first, one bit per clock, through a single-bit full-subtract cell with a borrow register.
- Inverse-direction companion to the combinational adder cells in the adders library.
- Trades latency for area; used where a wide parallel subtractor is not justified.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- borrow_in  input  1  initial borrow
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- diff  output  WIDTH  a - b - borrow_in mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 iff unsigned a < b + borrow_in
- overflow  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Reset (rst high at a clk edge, any state):
  - state <= IDLE.
  - in_ready=1, out_valid=0, diff=0, borrow_out=0, overflow=0, bit counter=0, borrow register=0.
  - rst overrides all other inputs in that cycle; a computation in progress is discarded, with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a and b into shift registers, borrow register <= borrow_in, save a[WIDTH-1] and b[WIDTH-1], counter <= 0, state <= RUN.
- RUN:
  - in_ready=0, out_valid=0; in_valid is ignored, with no queuing.
  - Each edge processes the current LSBs a0, b0 with borrow br:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d is shifted into the result register from the MSB side.
  - Operand registers shift right by 1; counter increments.
  - The edge processing bit WIDTH-1 also loads:
    - borrow_out <= br_next
    - overflow <= (a_msb != b_msb) & (d != a_msb), using the saved operand MSBs and the new result MSB
    - state <= DONE
- DONE:
  - out_valid=1, in_ready=0.
  - diff, borrow_out and overflow are stable and unchanged while out_valid=1 and out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: state <= IDLE and out_valid falls.
  - diff, borrow_out and overflow retain their last values in IDLE; they are not cleared.
- Latency:
  - Acceptance edge T0; bits are processed on edges T1..TWIDTH.
  - out_valid is high from edge TWIDTH through the edge on which out_ready is sampled high.
  - Minimum result latency is WIDTH edges after acceptance.
- Throughput: one operation per WIDTH+2 cycles at best (accept, WIDTH bit cycles, handoff). in_ready rises the cycle after the out_ready handshake; there is no same-cycle output/input overlap.
- out_ready is ignored outside DONE.
- Widths: all arithmetic is modulo 2^WIDTH. The counter is sized ceil(log2(WIDTH))+1 bits so that WIDTH-1 is reachable without wrap ambiguity.
- No combinational path from any input to any output except through the FSM state. Outputs are registered or decoded from state only.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, borrow_in=0 -> after 8 bit cycles out_valid=1, diff=0x02, borrow_out=0, overflow=0.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, overflow=0. Then a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and diff/borrow_out/overflow are constant. Raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Pulse in_valid with different operands (0xAA, 0x11) during RUN of 0x05-0x03 -> ignored; the result is still 0x02, and 0xAA-0x11 is not computed unless re-presented in IDLE.
- Assert rst for one edge at bit cycle 4 of a run -> the next cycle shows in_ready=1, out_valid=0, diff=0, borrow_out=0, overflow=0. A new operation (0x10-0x01) then completes with diff=0x0F and borrow_out=0.
